exe_mem_stage: RTL and testbench
================================

// Module: exe_mem_stage
// PURPOSE
// - EXE stage plus EXE/MEM pipeline register.
// - Consumes the registered ID/EXE outputs (exe_*): operand select with MEM/WB forwarding, 3-bit ALU, and a Z flag register.
// - Registers the ALU result and control into mem_* outputs for the MEM stage, with hold for memory stalls.
// PARAMETERS
// - WIDTH, 32: datapath width. Only 32 is supported; the shift amount is fixed at 5 bits.
// PORTS
// - clk               in   1      clock; all state updates on posedge
// - clrn              in   1      synchronous active-low reset
// - hold              in   1      1 = freeze all state (MEM stall)
// - exe_a, exe_b      in   32     register operands from ID/EXE
// - exe_imm           in   32     extended immediate; [10:6] = shamt
// - exe_rn            in   5      destination register
// - exe_aluc          in   3      ALU op
// - exe_alu_a_select  in   2      A mux select
// - exe_alu_b_select  in   2      B mux select
// - exe_wreg, exe_m2reg, exe_wmem, exe_wz  in  1 each  control bits
// - wb_data           in   32     WB-stage result, for forwarding
// - mem_wreg, mem_m2reg, mem_wmem  out  1 each  registered control
// - mem_alu           out  32     registered ALU result
// - mem_b             out  32     registered store data (= exe_b)
// - mem_rn            out  5      registered destination register
// - z_flag            out  1      Z flag register, read by ID branch logic
// - mem_ovf           out  1      registered overflow; present only with EXE_OVF_TRAP_EN
// BEHAVIOUR
// - Reset (clrn==0 at posedge): every output register <= 0, including z_flag (and mem_ovf).
// - Priority: clrn, then hold, then normal update.
// - A mux:
//   - 00: exe_a
//   - 01: {27'b0, exe_imm[10:6]}
//   - 10: mem_alu (EXE->EXE forward)
//   - 11: wb_data
// - B mux:
//   - 00: exe_b
//   - 01: exe_imm
//   - 10: mem_alu
//   - 11: wb_data
// - ALU (combinational, result r):
//   - 000: A+B
//   - 001: A-B
//   - 010: A&B
//   - 011: A|B
//   - 100: A^B
//   - 101: B<<A[4:0]
//   - 110: B>>A[4:0] (logical)
//   - 111: B>>>A[4:0] (arithmetic)
//   - Add/sub results are 32-bit and wrap modulo 2^32.
// - Normal posedge (clrn=1, hold=0):
//   - mem_alu<=r, mem_b<=exe_b, mem_rn<=exe_rn.
//   - mem_wreg<=exe_wreg, mem_m2reg<=exe_m2reg, mem_wmem<=exe_wmem.
// - Z flag: if exe_wz, z_flag <= (r==0); otherwise z_flag holds.
// - hold=1: all outputs and z_flag keep their values. Inputs are ignored for that cycle; upstream must also hold.
// - Latency: one cycle, exe_* to mem_*.
// - z_flag is visible the cycle after the writing instruction leaves EXE.
// - Forward sel 10 uses the current mem_alu, i.e. the previous instruction's result.
// - Bubble: upstream zeroes exe_wreg/exe_wmem/exe_wz. mem_* then carries no side effects and z_flag is untouched.
// - No internal FSM beyond the pipeline and flag registers. Reset mid-stream discards the in-flight instruction.
// CONFIGURATION
// - Macro EXE_OVF_TRAP_EN. When defined:
//   - ovf = signed overflow of 000/001.
//   - On ovf, at that posedge: mem_wreg<=0, mem_wmem<=0, z_flag not written, mem_ovf<=1.
//   - Otherwise mem_ovf<=0. mem_ovf follows hold and reset like the other outputs.
// - When not defined: mem_ovf does not exist and overflow wraps silently.
// TESTING
// - Reset: clrn=0 for 2 cycles with random inputs -> all mem_*=0, z_flag=0.
// - Add: a=5, b=7, sel=00/00, aluc=000, wreg=1 -> next cycle mem_alu=12, mem_wreg=1.
// - Immediate: sel_b=01, imm=0xFFFFFFFF, aluc=000, a=1, wz=1 -> mem_alu=0, z_flag=1.
//   - Next instruction with wz=0 and a nonzero result -> z_flag stays 1.
// - Forwarding: instruction 1 gives mem_alu=0x10; instruction 2 with sel_a=10, b=3, aluc=001 -> mem_alu=0x0D.
//   - Instruction 3: sel_b=11, wb_data=0x80, a=0xF0, aluc=010 -> mem_alu=0x80.
// - Shifts: imm[10:6]=4, sel_a=01, b=0x80000000.
//   - aluc=110 -> 0x08000000; aluc=111 -> 0xF8000000.
// - Hold: hold=1 for 3 cycles while inputs change -> outputs and z_flag frozen.
//   - hold=1 with clrn=0 -> reset wins.
//   - EXE_OVF_TRAP_EN: 0x7FFFFFFF+1 with wreg=1 -> mem_ovf=1, mem_wreg=0.

Source files
------------

// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE stage (forwarding muxes, ALU, Z flag) plus EXE/MEM register; EXE_OVF_TRAP_EN adds a signed-overflow trap on mem_ovf
module exe_mem_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             hold,
  input  logic [WIDTH-1:0] exe_a,
  input  logic [WIDTH-1:0] exe_b,
  input  logic [WIDTH-1:0] exe_imm,
  input  logic [4:0]       exe_rn,
  input  logic [2:0]       exe_aluc,
  input  logic [1:0]       exe_alu_a_select,
  input  logic [1:0]       exe_alu_b_select,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic             exe_wmem,
  input  logic             exe_wz,
  input  logic [WIDTH-1:0] wb_data,
  output logic             mem_wreg,
  output logic             mem_m2reg,
  output logic             mem_wmem,
  output logic [WIDTH-1:0] mem_alu,
  output logic [WIDTH-1:0] mem_b,
  output logic [4:0]       mem_rn,
  output logic             z_flag
`ifdef EXE_OVF_TRAP_EN
  ,
  output logic             mem_ovf
`endif
);
  logic [WIDTH-1:0] a, b, r;
  logic trap;
  always_comb begin
    a = exe_alu_a_select == 2'd0 ? exe_a :
        exe_alu_a_select == 2'd1 ? {{(WIDTH-5){1'b0}}, exe_imm[10:6]} :
        exe_alu_a_select == 2'd2 ? mem_alu : wb_data;
    b = exe_alu_b_select == 2'd0 ? exe_b :
        exe_alu_b_select == 2'd1 ? exe_imm :
        exe_alu_b_select == 2'd2 ? mem_alu : wb_data;
    case (exe_aluc)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = b << a[4:0];
      3'd6:    r = b >> a[4:0];
      default: r = $signed(b) >>> a[4:0];
    endcase
  end
`ifdef EXE_OVF_TRAP_EN
  // overflow when operand signs (after sub inversion) agree but the result sign differs
  assign trap = (exe_aluc == 3'd0 && a[WIDTH-1] == b[WIDTH-1] && r[WIDTH-1] != a[WIDTH-1]) ||
                (exe_aluc == 3'd1 && a[WIDTH-1] != b[WIDTH-1] && r[WIDTH-1] != a[WIDTH-1]);
`else
  assign trap = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!clrn) begin
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_wmem  <= 1'b0;
      mem_alu   <= '0;
      mem_b     <= '0;
      mem_rn    <= '0;
      z_flag    <= 1'b0;
`ifdef EXE_OVF_TRAP_EN
      mem_ovf   <= 1'b0;
`endif
    end else if (!hold) begin
      mem_wreg  <= exe_wreg & ~trap;
      mem_m2reg <= exe_m2reg;
      mem_wmem  <= exe_wmem & ~trap;
      mem_alu   <= r;
      mem_b     <= exe_b;
      mem_rn    <= exe_rn;
      if (exe_wz && !trap) z_flag <= (r == '0);
`ifdef EXE_OVF_TRAP_EN
      mem_ovf   <= trap;
`endif
    end
  end
endmodule

// File: tb/tb_exe_mem_stage.sv
// tb_exe_mem_stage: directed and random checks of exe_mem_stage against a behavioural model; honours EXE_OVF_TRAP_EN
module tb_exe_mem_stage;
  logic clk = 0, clrn, hold;
  logic [31:0] exe_a, exe_b, exe_imm, wb_data;
  logic [4:0] exe_rn;
  logic [2:0] exe_aluc;
  logic [1:0] exe_alu_a_select, exe_alu_b_select;
  logic exe_wreg, exe_m2reg, exe_wmem, exe_wz;
  logic mem_wreg, mem_m2reg, mem_wmem, z_flag;
  logic [31:0] mem_alu, mem_b;
  logic [4:0] mem_rn;
  logic mem_ovf;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_alu, m_b;
  logic [4:0] m_rn;
  logic m_wreg, m_m2reg, m_wmem, m_z, m_ovf;

  exe_mem_stage dut (
    .clk(clk), .clrn(clrn), .hold(hold),
    .exe_a(exe_a), .exe_b(exe_b), .exe_imm(exe_imm), .exe_rn(exe_rn),
    .exe_aluc(exe_aluc), .exe_alu_a_select(exe_alu_a_select), .exe_alu_b_select(exe_alu_b_select),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem), .exe_wz(exe_wz),
    .wb_data(wb_data),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
    .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn), .z_flag(z_flag)
`ifdef EXE_OVF_TRAP_EN
    , .mem_ovf(mem_ovf)
`endif
  );
`ifndef EXE_OVF_TRAP_EN
  assign mem_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] v0, v1, v2, v3);
    logic [31:0] v[4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    return v[s];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("mem_alu", mem_alu, m_alu);
    chk("mem_b", mem_b, m_b);
    chk("mem_rn", 32'(mem_rn), 32'(m_rn));
    chk("mem_wreg", 32'(mem_wreg), 32'(m_wreg));
    chk("mem_m2reg", 32'(mem_m2reg), 32'(m_m2reg));
    chk("mem_wmem", 32'(mem_wmem), 32'(m_wmem));
    chk("z_flag", 32'(z_flag), 32'(m_z));
`ifdef EXE_OVF_TRAP_EN
    chk("mem_ovf", 32'(mem_ovf), 32'(m_ovf));
`endif
  endtask

  // model evaluates the instruction from inputs, then applies it at the edge
  task automatic tick();
    logic [31:0] a, b, r;
    longint exact;
    logic ovf;
    a = pick(exe_alu_a_select, exe_a, {27'd0, exe_imm[10:6]}, m_alu, wb_data);
    b = pick(exe_alu_b_select, exe_b, exe_imm, m_alu, wb_data);
    case (exe_aluc)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 32'(longint'(b) * (longint'(1) << a[4:0]));
      3'd6: r = b / (32'd1 << a[4:0]);
      default: r = 32'($signed(b) >>> a[4:0]);
    endcase
    exact = exe_aluc == 3'd0 ? longint'($signed(a)) + longint'($signed(b)) : longint'($signed(a)) - longint'($signed(b));
`ifdef EXE_OVF_TRAP_EN
    ovf = exe_aluc < 3'd2 && exact != longint'($signed(r));
`else
    ovf = 1'b0;
`endif
    @(posedge clk);
    if (!clrn) begin
      {m_alu, m_b, m_rn, m_wreg, m_m2reg, m_wmem, m_z, m_ovf} = '0;
    end else if (!hold) begin
      m_alu = r; m_b = exe_b; m_rn = exe_rn;
      m_wreg = exe_wreg && !ovf; m_m2reg = exe_m2reg; m_wmem = exe_wmem && !ovf;
      if (exe_wz && !ovf) m_z = (r == 0);
      m_ovf = ovf;
    end
    #1;
    chk_all();
  endtask

  task automatic rnd();
    exe_a = $urandom; exe_b = $urandom; exe_imm = $urandom; wb_data = $urandom;
    exe_rn = 5'($urandom); exe_aluc = 3'($urandom);
    exe_alu_a_select = 2'($urandom); exe_alu_b_select = 2'($urandom);
    {exe_wreg, exe_m2reg, exe_wmem, exe_wz} = 4'($urandom);
  endtask

  task automatic op(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] c,
                    input logic [31:0] a, input logic [31:0] b, input logic wr, input logic wz);
    exe_alu_a_select = sa; exe_alu_b_select = sb; exe_aluc = c;
    exe_a = a; exe_b = b; exe_wreg = wr; exe_wz = wz; exe_m2reg = 0; exe_wmem = 0;
  endtask

  initial begin
    {m_alu, m_b, m_rn, m_wreg, m_m2reg, m_wmem, m_z, m_ovf} = '0;
    clrn = 0; hold = 0;
    rnd(); tick();
    rnd(); tick();
    chk("reset_alu", mem_alu, 32'd0);
    chk("reset_z", 32'(z_flag), 32'd0);
    clrn = 1;
    op(0, 0, 3'd0, 5, 7, 1, 0); tick();
    chk("add", mem_alu, 32'd12);
    chk("add_wreg", 32'(mem_wreg), 32'd1);
    op(0, 1, 3'd0, 1, 0, 0, 1); exe_imm = 32'hFFFF_FFFF; tick();
    chk("imm_alu", mem_alu, 32'd0);
    chk("imm_z", 32'(z_flag), 32'd1);
    op(0, 0, 3'd0, 5, 3, 1, 0); tick();
    chk("z_keep", 32'(z_flag), 32'd1);
    op(0, 0, 3'd0, 32'h10, 0, 1, 0); tick();
    op(2, 0, 3'd1, 0, 3, 1, 0); tick();
    chk("fwd_mem", mem_alu, 32'h0D);
    op(0, 3, 3'd2, 32'hF0, 0, 1, 0); wb_data = 32'h80; tick();
    chk("fwd_wb", mem_alu, 32'h80);
    op(1, 0, 3'd6, 0, 32'h8000_0000, 1, 0); exe_imm = 32'd4 << 6; tick();
    chk("srl", mem_alu, 32'h0800_0000);
    exe_aluc = 3'd7; tick();
    chk("sra", mem_alu, 32'hF800_0000);
    hold = 1;
    for (int i = 0; i < 3; i++) begin rnd(); tick(); end
    chk("hold_alu", mem_alu, 32'hF800_0000);
    clrn = 0; rnd(); tick();
    chk("hold_rst", mem_alu, 32'd0);
    hold = 0; clrn = 1;
`ifdef EXE_OVF_TRAP_EN
    op(0, 0, 3'd0, 32'h7FFF_FFFF, 1, 1, 0); tick();
    chk("ovf", 32'(mem_ovf), 32'd1);
    chk("ovf_wreg", 32'(mem_wreg), 32'd0);
`endif
    for (int i = 0; i < 400; i++) begin
      rnd();
      clrn = ($urandom_range(0, 39) != 0);
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) exe_aluc = 3'($urandom_range(0, 1));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
